// File: rtl/lift_pkg.sv
// Shared encodings for the lift call scheduler: controller state codes, FSM states,
// floor width, direction constants and the idle-homing threshold.
package lift_pkg;

  localparam int FLOOR_W = 2;

  localparam logic [1:0] LS_IDLE = 2'b00;
  localparam logic [1:0] LS_UP   = 2'b10;
  localparam logic [1:0] LS_DOWN = 2'b01;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int HOME_IDLE_CYCLES = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_TRAVEL,
    S_DWELL
  } state_t;

  // 2'b11 is not a motion code, so it counts as idle.
  function automatic logic ls_moving(input logic [1:0] ls);
    return (ls == LS_UP) || (ls == LS_DOWN);
  endfunction

endpackage

// File: rtl/lift_target_picker.sv
// Combinational SCAN pick: nearest pending floor strictly ahead in dir, else nearest
// pending floor the other way (with new_dir flipped). Zero latency, no flow control.
module lift_target_picker
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = 4
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  dir,
  output logic [FLOOR_W-1:0]    target,
  output logic                  new_dir,
  output logic                  found
);

  logic [FLOOR_W-1:0] up_tgt;
  logic [FLOOR_W-1:0] dn_tgt;
  logic [FLOOR_W-1:0] fl;
  logic               up_found;
  logic               dn_found;

  // Descending scan leaves the lowest floor above; ascending scan the highest below.
  always_comb begin
    up_found = 1'b0;
    dn_found = 1'b0;
    up_tgt   = cur_floor;
    dn_tgt   = cur_floor;
    fl       = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      fl = FLOOR_W'(i);
      if (pending[i] && (fl > cur_floor)) begin
        up_found = 1'b1;
        up_tgt   = fl;
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      fl = FLOOR_W'(i);
      if (pending[i] && (fl < cur_floor)) begin
        dn_found = 1'b1;
        dn_tgt   = fl;
      end
    end
  end

  always_comb begin
    found   = up_found | dn_found;
    target  = up_tgt;
    new_dir = DIR_UP;
    if (dir == DIR_UP) begin
      if (!up_found) begin
        target  = dn_tgt;
        new_dir = DIR_DOWN;
      end
    end else if (dn_found) begin
      target  = dn_tgt;
      new_dir = DIR_DOWN;
    end
  end

endmodule

// File: rtl/lift_call_scheduler.sv
// SCAN call scheduler driving req_floor to the lift controller; 1-cycle target selection,
// waits on lift_state for arrival (timeout-forced). Optional LIFT_HOME_EN: idle homing to floor 0.
module lift_call_scheduler
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS     = 4,
  parameter int DWELL_CYCLES   = 4,
  parameter int TRAVEL_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [1:0]            lift_state,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  served_valid,
  output logic [FLOOR_W-1:0]    served_floor,
  output logic                  busy
);

  state_t                state;
  state_t                state_nxt;
  logic [FLOOR_W-1:0]    cur_floor;
  logic [FLOOR_W-1:0]    pick_target;
  logic [FLOOR_W-1:0]    serve_floor;
  logic                  dir;
  logic                  pick_dir;
  logic                  pick_found;
  logic                  seen_move;
  logic                  here_call;
  logic                  travel_done;
  logic                  serve;
  logic                  homing;
  logic                  home_go;
  logic [3:0]            tcnt;
  logic [3:0]            dcnt;
  logic [NUM_FLOORS-1:0] clr_mask;

  lift_target_picker #(
    .NUM_FLOORS(NUM_FLOORS)
  ) u_picker (
    .pending  (pending),
    .cur_floor(cur_floor),
    .dir      (dir),
    .target   (pick_target),
    .new_dir  (pick_dir),
    .found    (pick_found)
  );

  assign here_call   = pending[cur_floor];
  // An idle code only counts as arrival once the controller has been seen moving.
  assign travel_done = (!ls_moving(lift_state) && seen_move) || (tcnt == 4'(TRAVEL_TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (here_call)                  state_nxt = S_DWELL;
        else if (home_go || pick_found) state_nxt = S_ISSUE;
      end
      S_ISSUE:  state_nxt = S_TRAVEL;
      S_TRAVEL: if (travel_done) state_nxt = homing ? S_IDLE : S_DWELL;
      S_DWELL:  if (dcnt <= 4'd1) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    serve       = 1'b0;
    serve_floor = cur_floor;
    clr_mask    = '0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE:   if (here_call) serve = 1'b1;
      S_TRAVEL: begin
        if (travel_done && !homing) begin
          serve       = 1'b1;
          serve_floor = req_floor;
        end
      end
      S_DWELL:  clr_mask = NUM_FLOORS'(1) << cur_floor;
      default:  ;
    endcase
    if (serve) clr_mask = NUM_FLOORS'(1) << serve_floor;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending      <= '0;
      served_valid <= 1'b0;
      served_floor <= '0;
      req_floor    <= '0;
      cur_floor    <= '0;
      dir          <= DIR_UP;
      tcnt         <= '0;
      dcnt         <= '0;
      seen_move    <= 1'b0;
    end else begin
      pending      <= (pending | call_btn) & ~clr_mask;
      served_valid <= serve;
      if (serve) served_floor <= serve_floor;
      case (state)
        S_IDLE: begin
          if (here_call) begin
            dcnt <= 4'(DWELL_CYCLES);
          end else if (home_go) begin
            req_floor <= '0;
          end else if (pick_found) begin
            req_floor <= pick_target;
            dir       <= pick_dir;
          end
        end
        S_ISSUE: begin
          tcnt      <= 4'd1;
          seen_move <= 1'b0;
        end
        S_TRAVEL: begin
          if (travel_done) begin
            cur_floor <= req_floor;
            if (homing) dir  <= DIR_UP;
            else        dcnt <= 4'(DWELL_CYCLES);
          end else begin
            if (tcnt != 4'hf) tcnt <= tcnt + 4'd1;
            if (ls_moving(lift_state)) seen_move <= 1'b1;
          end
        end
        S_DWELL: if (dcnt != 4'd0) dcnt <= dcnt - 4'd1;
        default: ;
      endcase
    end
  end

`ifdef LIFT_HOME_EN
  logic [3:0] idle_cnt;
  logic       idle_parked;

  assign idle_parked = (state == S_IDLE) && (pending == '0) && (cur_floor != '0);
  assign home_go     = idle_parked && (idle_cnt == 4'(HOME_IDLE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      homing   <= 1'b0;
    end else begin
      if (!idle_parked)         idle_cnt <= '0;
      else if (idle_cnt != 4'hf) idle_cnt <= idle_cnt + 4'd1;
      if (home_go)                               homing <= 1'b1;
      else if ((state == S_TRAVEL) && travel_done) homing <= 1'b0;
    end
  end
`else
  assign home_go = 1'b0;
  assign homing  = 1'b0;
`endif

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler with a one-floor-per-cycle controller model.
module tb_lift_call_scheduler;
  import lift_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] call_btn;
  logic [1:0] lift_state;
  logic [1:0] req_floor;
  logic [3:0] pending;
  logic       served_valid;
  logic [1:0] served_floor;
  logic       busy;

  int n_asrt;
  int n_fail;
  int n_pulse;
  int ctl_pos;
  bit stuck;
  int p0;
  int n;

  lift_call_scheduler #(
    .NUM_FLOORS    (4),
    .DWELL_CYCLES  (4),
    .TRAVEL_TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .call_btn    (call_btn),
    .lift_state  (lift_state),
    .req_floor   (req_floor),
    .pending     (pending),
    .served_valid(served_valid),
    .served_floor(served_floor),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial lift_state = LS_IDLE;
  always @(negedge clk) begin
    if (stuck) begin
      lift_state = LS_UP;
    end else if (int'(req_floor) > ctl_pos) begin
      lift_state = LS_UP;
      ctl_pos++;
    end else if (int'(req_floor) < ctl_pos) begin
      lift_state = LS_DOWN;
      ctl_pos--;
    end else begin
      lift_state = LS_IDLE;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (served_valid) n_pulse++;
  endtask

  task automatic wait_served(input string tag, output int cyc);
    cyc = 0;
    while (!served_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_served"}, 32'(served_valid), 1);
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 40) begin
      tick();
      c++;
    end
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic serve_trip(input logic [3:0] btn, input int exp_floor, input string tag);
    int c;
    call_btn = btn;
    tick();
    call_btn = '0;
    wait_served(tag, c);
    chk({tag, "_floor"}, 32'(served_floor), exp_floor);
    wait_idle(tag);
  endtask

  initial begin
    n_asrt = 0; n_fail = 0; n_pulse = 0;
    reset = 1'b0; call_btn = '0; stuck = 1'b0; ctl_pos = 0;
    repeat (2) tick();
    chk("rst_req", 32'(req_floor), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_sv", 32'(served_valid), 0);
    chk("rst_sf", 32'(served_floor), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    tick();

    // Single call to floor 3 from floor 0.
    call_btn = 4'b1000;
    tick();
    chk("t2_pend", 32'(pending), 8);
    chk("t2_req_early", 32'(req_floor), 0);
    call_btn = '0;
    tick();
    chk("t2_req", 32'(req_floor), 3);
    chk("t2_busy", 32'(busy), 1);
    p0 = n_pulse;
    wait_served("t2", n);
    chk("t2_floor", 32'(served_floor), 3);
    chk("t2_pend_clr", 32'(pending), 0);
    repeat (3) tick();
    chk("t2_dwell_busy", 32'(busy), 1);
    tick();
    chk("t2_dwell_end", 32'(busy), 0);
    chk("t2_pulses", 32'(n_pulse - p0), 1);
    chk("t2_sf_hold", 32'(served_floor), 3);

    // Reach floor 1 heading up, then SCAN through 3, 2, 0, 3.
    serve_trip(4'b0001, 0, "t3a");
    serve_trip(4'b0010, 1, "t3b");
    call_btn = 4'b1001;
    tick();
    call_btn = '0;
    wait_served("t3c", n);
    chk("t3c_floor", 32'(served_floor), 3);
    chk("t3c_pend", 32'(pending), 1);
    call_btn = 4'b0100;
    tick();
    call_btn = '0;
    wait_idle("t3c");
    wait_served("t3d", n);
    chk("t3d_floor", 32'(served_floor), 2);
    call_btn = 4'b1000;
    tick();
    call_btn = '0;
    wait_idle("t3d");
    wait_served("t3e", n);
    chk("t3e_floor_dir_down", 32'(served_floor), 0);
    wait_idle("t3e");
    wait_served("t3f", n);
    chk("t3f_floor", 32'(served_floor), 3);

    // Current-floor button held through the door-open period is absorbed.
    call_btn = 4'b1000;
    p0 = n_pulse;
    wait_idle("t4");
    chk("t4_pend_dwell", 32'(pending), 0);
    call_btn = '0;
    repeat (4) tick();
    chk("t4_pend", 32'(pending), 0);
    chk("t4_pulses", 32'(n_pulse - p0), 0);
    chk("t4_busy", 32'(busy), 0);

    // Call at the parked floor is served without travel.
    call_btn = 4'b1000;
    tick();
    call_btn = '0;
    chk("t5_pend", 32'(pending), 8);
    tick();
    chk("t5_sv", 32'(served_valid), 1);
    chk("t5_sf", 32'(served_floor), 3);
    chk("t5_pend_clr", 32'(pending), 0);
    wait_idle("t5");

    // Controller stuck moving: arrival forced after 8 TRAVEL cycles.
    stuck = 1'b1;
    call_btn = 4'b0010;
    tick();
    call_btn = '0;
    tick();
    chk("t6_req", 32'(req_floor), 1);
    wait_served("t6", n);
    chk("t6_lat", 32'(n), 9);
    chk("t6_floor", 32'(served_floor), 1);
    stuck = 1'b0;
    ctl_pos = 1;
    wait_idle("t6");

    // Asynchronous reset in the middle of a trip.
    stuck = 1'b1;
    call_btn = 4'b0001;
    tick();
    call_btn = '0;
    repeat (4) tick();
    chk("t7_pre_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("t7_req", 32'(req_floor), 0);
    chk("t7_pend", 32'(pending), 0);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_sv", 32'(served_valid), 0);
    chk("t7_sf", 32'(served_floor), 0);
    tick();
    reset = 1'b1;
    stuck = 1'b0;
    ctl_pos = 0;
    p0 = n_pulse;
    repeat (3) tick();
    chk("t7_pulses", 32'(n_pulse - p0), 0);
    chk("t7_busy_after", 32'(busy), 0);

    // Park at floor 2 with no calls.
    serve_trip(4'b0100, 2, "t8a");
    p0 = n_pulse;
    repeat (4) tick();
    chk("t8_req_park", 32'(req_floor), 2);
`ifdef LIFT_HOME_EN
    tick();
    chk("t8_home_req", 32'(req_floor), 0);
    wait_idle("t8_home");
    chk("t8_home_pulses", 32'(n_pulse - p0), 0);
    chk("t8_home_req_end", 32'(req_floor), 0);
    serve_trip(4'b0010, 1, "t8b");
`else
    repeat (10) tick();
    chk("t8_req_stay", 32'(req_floor), 2);
    chk("t8_busy", 32'(busy), 0);
    chk("t8_pulses", 32'(n_pulse - p0), 0);
    serve_trip(4'b0010, 1, "t8b");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/lift_call_scheduler.md
Name: lift_call_scheduler

Overview:
- Requesting side of the lift controller interface.
- Latches per-floor call buttons and picks the next floor to serve using SCAN (keep direction while calls remain ahead).
- Drives req_floor into the lift controller and watches the controller's lift_state to detect arrival.
- Clears served calls and reports them to the lamp/indicator logic.

Parameters:
- NUM_FLOORS, 4, number of floors; fixed at 4 to match the 2-bit floor bus.
- DWELL_CYCLES, 4, door-open cycles after arrival before the next dispatch; range 1..15.
- TRAVEL_TIMEOUT, 8, maximum cycles in TRAVEL before arrival is forced; range 2..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low.
- call_btn  input  4  call request per floor; level or pulse; any high cycle registers the call.
- lift_state  input  2  controller state: 00 idle, 10 up, 01 down; 11 treated as idle.
- req_floor  output  2  target floor presented to the controller.
- pending  output  4  registered outstanding calls (lamps).
- served_valid  output  1  one-cycle pulse on arrival.
- served_floor  output  2  floor just served; valid with served_valid and held afterwards.
- busy  output  1  high in every state except S_IDLE.

Behaviour:
- Reset values: req_floor=0, pending=0, served_valid=0, served_floor=0, busy=0. Internal: cur_floor=0, dir=up, state=S_IDLE, counters=0.
- Pending register: pending <= (pending | call_btn) & ~clr_mask each cycle.
  - clr_mask is the served floor's bit in the arrival cycle.
  - clr_mask is the cur_floor bit throughout S_DWELL, so a door-open call is absorbed.
  - Clear wins when set and clear hit the same bit in the same cycle.
- FSM states: S_IDLE, S_ISSUE, S_TRAVEL, S_DWELL.
- S_IDLE, pending==0: stay; req_floor holds cur_floor, so the controller stays idle.
- S_IDLE, pending[cur_floor]=1: treat as arrival with no travel.
  - served_valid=1 for one cycle, served_floor=cur_floor, clear the bit, go to S_DWELL.
- S_IDLE, otherwise: target = nearest pending floor strictly ahead in dir.
  - If none is ahead, flip dir and take the nearest pending floor in the new direction.
  - Register req_floor=target and go to S_ISSUE. Selection latency is 1 cycle.
- S_ISSUE: hold req_floor for 1 cycle so the controller's negedge sample sees a stable value; go to S_TRAVEL.
- S_TRAVEL: arrival occurs on the first lift_state==idle sample after at least one non-idle sample, or when the travel counter reaches TRAVEL_TIMEOUT.
  - On arrival: served_valid pulse, served_floor=target, cur_floor=target, clear pending[target], load the dwell counter, go to S_DWELL.
  - req_floor stays at target throughout.
- S_DWELL: count DWELL_CYCLES cycles, then go to S_IDLE. New calls on other floors accumulate meanwhile.
- Direction bookkeeping: dir updates only on a flip in S_IDLE.
  - At floor 3 with no calls above, dir becomes down.
  - At floor 0 with no calls below, dir becomes up.
- Calls for the current target arriving during TRAVEL simply remain set until arrival clears them.
- Reset mid-operation returns all state and outputs to reset values on the same edge; no pulse is emitted.
- Width rules: floor compares are unsigned 2-bit. Counters are 4-bit saturating.

Optional Feature:
- Macro: LIFT_HOME_EN.
- Defined: after 5 consecutive S_IDLE cycles with pending==0 and cur_floor!=0, issue a homing trip to floor 0.
  - The trip passes through S_ISSUE and S_TRAVEL.
  - No served_valid pulse is emitted; cur_floor=0 and dir=up afterwards.
  - A call arriving during the homing trip is queued normally.
- Undefined: the lift parks at the last served floor indefinitely.

Decomposition:
- Package lift_pkg holds:
  - lift_state encodings LS_IDLE=2'b00, LS_UP=2'b10, LS_DOWN=2'b01;
  - the FSM state typedef;
  - FLOOR_W=2 and DIR_UP/DIR_DOWN constants;
  - the idle-homing threshold of 5.
- Sub-module lift_target_picker: combinational SCAN selection.
  - Inputs: pending, cur_floor, dir.
  - Outputs: target, new_dir, found.

Test Plan:
- Reset low while busy mid-TRAVEL, release -> all outputs 0 and state S_IDLE on the next edge; no served_valid.
- From floor 0, pulse call_btn=4'b1000; controller model gives 10 then 00 -> req_floor=3 two cycles after the call; served_valid with served_floor=3; pending=0.
- At floor 1 with dir up, pending=4'b1001 -> serve 3 first, then 0; dir flips to down.
- call_btn[cur_floor] held high during S_DWELL -> pending bit stays 0; no second served_valid.
- Controller model stuck at 10 -> forced arrival after 8 TRAVEL cycles; served_valid asserted.
- LIFT_HOME_EN defined, parked at floor 2, no calls -> after 5 idle cycles req_floor=0; no served_valid; later calls are served normally.
